// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file completer: FSM encoding,
// wait-counter width and byte-offset helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned WAIT_CNT_W = 4;

  // Number of PADDR bits that select a byte within one DATA_W-wide register.
  function automatic int unsigned byte_off_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Access-phase wait-state counter: cleared on SETUP, counts up to WAIT_STATES
// and raises o_done once the programmed number of wait cycles has elapsed.
module apb_wait_ctr
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_done
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  assign o_done = (r_cnt == WAIT_CNT_W'(WAIT_STATES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_done) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// Parametrised APB register-file completer with programmable wait states,
// error response and per-register write pulses. Define APB_PSTRB_EN for PSTRB.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       NUM_REGS    = 16,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic [DATA_W-1:0]          PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0]        PSTRB,
`endif
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int unsigned       NBYTES   = DATA_W / 8;
  localparam int unsigned       OFF_W    = byte_off_bits(DATA_W);
  localparam int unsigned       IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  apb_state_e          r_state;
  apb_state_e          w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [NBYTES-1:0]   w_strb;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic [ADDR_W-1:0]   w_idx_full;
  logic [IDX_W-1:0]    w_idx;
  logic                w_done;
  logic                w_access;
  logic                w_complete;
  logic                w_err;
  logic                w_commit;

  apb_wait_ctr #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_ctr (
    .i_clk  (PCLK),
    .i_rst_n(PRESETn),
    .i_clr  (r_state == SETUP),
    .i_inc  (w_access && PSEL && PENABLE),
    .o_done (w_done)
  );

  assign w_access   = (r_state == ACCESS);
  assign w_complete = w_access && w_done;
  assign w_idx_full = r_addr >> OFF_W;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  // Range check is done at 32 bits so NUM_REGS == 2**ADDR_W cannot wrap.
  assign w_err      = (32'(w_idx_full) >= NUM_REGS) || ((r_addr & OFF_MASK) != '0);
  assign w_commit   = w_complete && r_write && !w_err && (|w_strb);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) w_next = SETUP;
      end
      SETUP: begin
        w_next = ACCESS;
      end
      ACCESS: begin
        if (w_done) begin
          w_next = (PSEL && !PENABLE) ? SETUP : IDLE;
        end else if (!(PSEL && PENABLE)) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == SETUP) begin
        r_addr  <= PADDR;
        r_write <= PWRITE;
      end
    end
  end

`ifdef APB_PSTRB_EN
  logic [NBYTES-1:0] r_strb;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_strb <= '0;
    end else if (r_state == SETUP) begin
      r_strb <= PSTRB;
    end
  end

  assign w_strb = r_strb;
`else
  assign w_strb = '1;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_wr_pulse[w_idx] <= 1'b1;
        for (int unsigned b = 0; b < NBYTES; b++) begin
          if (w_strb[b]) r_regs[w_idx][b*8 +: 8] <= PWDATA[b*8 +: 8];
        end
      end
    end
  end

  assign PREADY   = w_complete;
  assign PSLVERR  = w_complete && w_err;
  assign PRDATA   = (w_access && !r_write && !w_err) ? r_regs[w_idx] : '0;
  assign wr_pulse = r_wr_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*DATA_W +: DATA_W] = r_regs[g];
  end

endmodule
